// File: rtl/axi_frame_reader.sv
// axi_frame_reader
//   AXI4 read master that fetches one stored frame from the framebuffer and
//   streams it out as AXI_DATA_WIDTH-bit words with valid/ready. One frame is
//   read per frame_start pulse. There is only one burst in flight at a time,
//   and every burst is a fixed-length INCR burst.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET  clock; synchronous active-high reset
//   frame_start, frame_sel    start pulse; buffer select sampled with it
//   busy, err, overrun        frame in progress; sticky error/overrun flags
//   M_AXI_AR*                 read address channel (static fields tied off)
//   M_AXI_R*                  read data channel
//   m_data/m_valid/m_last     output word stream; m_last marks the frame end
//   m_ready                   downstream ready
module axi_frame_reader #(
    parameter int AXI_ID_WIDTH = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BURST_LEN = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0040_0000,
    parameter int FRAME_BURSTS = 3600
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic                      frame_start,
    input  logic                      frame_sel,
    output logic                      busy,
    output logic                      err,
    output logic                      overrun,
    output logic [AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                M_AXI_ARLEN,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic                      M_AXI_ARLOCK,
    output logic [3:0]                M_AXI_ARCACHE,
    output logic [2:0]                M_AXI_ARPROT,
    output logic [3:0]                M_AXI_ARQOS,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RLAST,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready
);
    localparam int DB      = AXI_DATA_WIDTH / 8;
    localparam int BEAT_W  = $clog2(BURST_LEN + 1);
    localparam int BURST_W = $clog2(FRAME_BURSTS + 1);
    localparam logic [BEAT_W-1:0]         BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]        BURST_LAST  = BURST_W'(FRAME_BURSTS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * DB);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;

    state_t state, state_nx;

    logic [BEAT_W-1:0]  beat_cnt;
    logic [BURST_W-1:0] burst_cnt;

    // Two-entry skid buffer: head feeds the output port, tail catches the
    // beat that arrives while the head is stalled.
    logic [AXI_DATA_WIDTH-1:0] head_data, tail_data;
    logic                      head_last, tail_last;
    logic [1:0]                count;

    logic pop, full, r_hs, beat_end, frame_end;

    // Static read-address fields.
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DB));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;

    // Read IDs are not checked: only one burst is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^M_AXI_RID;

    assign m_valid = (count != 2'd0);
    assign m_data  = head_data;
    // head_last can be stale once the buffer drains, so gate it with valid.
    assign m_last  = head_last && m_valid;
    assign pop     = m_valid && m_ready;

    // A pop this cycle frees a slot, so a full buffer can still accept a
    // beat in the same cycle and sustain one word per clock.
    assign full      = (count == 2'd2) && !pop;
    assign r_hs      = M_AXI_RVALID && (state == DATA) && !full;
    assign beat_end  = r_hs && (beat_cnt == BEAT_LAST);
    assign frame_end = beat_end && (burst_cnt == BURST_LAST);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_nx      = state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) state_nx = ADDR;
            end
            ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nx = DATA;
            end
            DATA: begin
                M_AXI_RREADY = !full;
                if (beat_end) state_nx = frame_end ? FLUSH : ADDR;
            end
            FLUSH: begin
                // The final word is the last one pushed, so its handshake
                // also leaves the buffer empty.
                if (pop && m_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            // NOTE: the buffer entries are reset too, because head_data drives m_data directly and must read zero after reset.
            M_AXI_ARADDR <= '0;
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            err          <= 1'b0;
            overrun      <= 1'b0;
            head_data    <= '0;
            tail_data    <= '0;
            head_last    <= 1'b0;
            tail_last    <= 1'b0;
            count        <= 2'd0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
            if (state == IDLE && frame_start) begin
                M_AXI_ARADDR <= BASE_ADDR + (frame_sel ? FRAME_STRIDE : '0);
                beat_cnt     <= '0;
                burst_cnt    <= '0;
            end

            if (frame_start && busy) overrun <= 1'b1;

            if (r_hs) begin
                // Errors are flagged but the data still flows and the burst
                // still counts; there is no retry.
                if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != (beat_cnt == BEAT_LAST))
                    err <= 1'b1;
                if (beat_cnt == BEAT_LAST) begin
                    beat_cnt     <= '0;
                    burst_cnt    <= burst_cnt + BURST_W'(1);
                    M_AXI_ARADDR <= M_AXI_ARADDR + BURST_BYTES;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end

            case ({r_hs, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= M_AXI_RDATA;
                        head_last <= frame_end;
                    end else begin
                        tail_data <= M_AXI_RDATA;
                        tail_last <= frame_end;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= M_AXI_RDATA;
                        head_last <= frame_end;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= M_AXI_RDATA;
                        tail_last <= frame_end;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_frame_reader.sv
// tb_axi_frame_reader
//   Self-checking bench. A small AXI slave returns memory word (addr-BASE)/16
//   at each address; the expected word stream and burst addresses come from
//   a frame-level model built from the buffer select alone.
module tb_axi_frame_reader;
    localparam int BL = 4;
    localparam int FB = 2;
    localparam logic [31:0] TB_BASE   = 32'h1000_0000;
    localparam logic [31:0] TB_STRIDE = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         frame_sel = 1'b0;
    logic         busy, err, overrun;
    logic [0:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [0:0]   rid = 1'b0;
    logic [127:0] rdata = '0;
    logic [1:0]   rresp = 2'b00;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [127:0] m_data;
    logic         m_valid, m_last;
    logic         m_ready = 1'b0;

    axi_frame_reader #(
        .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128),
        .BURST_LEN(BL), .BASE_ADDR(TB_BASE), .FRAME_STRIDE(TB_STRIDE),
        .FRAME_BURSTS(FB)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .frame_start(frame_start), .frame_sel(frame_sel),
        .busy(busy), .err(err), .overrun(overrun),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
        .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
        .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame-level reference model.
    logic [127:0] exp_w[$];
    bit           exp_l[$];
    logic [31:0]  exp_ar[$];

    task automatic build_expected(input bit sel);
        int base_w;
        exp_w.delete(); exp_l.delete(); exp_ar.delete();
        base_w = sel ? int'(TB_STRIDE) / 16 : 0;
        for (int b = 0; b < FB; b++) begin
            exp_ar.push_back(TB_BASE + (sel ? TB_STRIDE : 32'h0) + 32'(b * BL * 16));
            for (int k = 0; k < BL; k++) begin
                exp_w.push_back(128'(base_w + b * BL + k));
                exp_l.push_back(b == FB - 1 && k == BL - 1);
            end
        end
    endtask

    // Slave and monitor configuration.
    int cfg_stall = 0;
    bit cfg_rv_rand = 1'b0;
    int cfg_mr_mode = 0;
    int cfg_resp_beat = -1;
    int cfg_last_beat = -1;
    bit mr_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    bit          pending = 1'b0;
    logic [31:0] raddr = '0;
    int          k_beat = 0, gbeat = 0, ar_wait = 0, occ = 0, cyc = 0;
    logic [31:0] first_ar = '0;
    bit          got_first_ar = 1'b0;
    bit          prev_m_stall = 1'b0, prev_m_last = 1'b0, prev_ar_wait = 1'b0;
    logic [127:0] prev_m_data = '0;
    logic [31:0] prev_araddr = '0;
    bit          last_done = 1'b0, expect_valid = 1'b0;

    // Handshakes are sampled at the falling edge (inputs are stable there
    // and reflect what the DUT sees at the next rising edge); the slave
    // drives its next values 1 time unit after the rising edge.
    always begin : slave_and_monitor
        bit s_rst, s_ar_hs, s_r_hs, s_m_hs, s_rvalid, s_arvalid;
        logic [31:0] s_araddr;
        @(negedge clk);
        s_rst     = rst;
        s_ar_hs   = arvalid && arready;
        s_r_hs    = rvalid && rready;
        s_m_hs    = m_valid && m_ready;
        s_rvalid  = rvalid;
        s_arvalid = arvalid;
        s_araddr  = araddr;
        if (s_rst) begin
            exp_w.delete(); exp_l.delete(); exp_ar.delete();
            occ = 0; got_first_ar = 1'b0;
            prev_m_stall = 1'b0; prev_ar_wait = 1'b0;
            last_done = 1'b0; expect_valid = 1'b0;
        end else begin
            if (prev_ar_wait) begin
                check("arvalid_held", arvalid, 1);
                check("araddr_held", araddr, prev_araddr);
            end
            if (s_ar_hs) begin
                if (!got_first_ar) begin
                    first_ar = araddr;
                    got_first_ar = 1'b1;
                end
                check("ar_expected", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) check("araddr", araddr, exp_ar.pop_front());
                check("arlen", arlen, BL - 1);
                check("arsize", arsize, 4);
                check("arburst", arburst, 1);
            end
            if (pending) check("rready", rready, !(occ == 2 && !s_m_hs));
            if (expect_valid) check("first_word_latency", m_valid, 1);
            if (prev_m_stall) begin
                check("m_valid_held", m_valid, 1);
                check("m_data_held", m_data, prev_m_data);
                check("m_last_held", m_last, prev_m_last);
            end
            if (last_done) check("busy_drop", busy, 0);
            last_done = 1'b0;
            if (s_m_hs) begin
                check("word_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    check("m_data", m_data, exp_w.pop_front());
                    check("m_last", m_last, exp_l.pop_front());
                end
                if (m_last) begin
                    check("busy_at_last", busy, 1);
                    last_done = 1'b1;
                end
            end
            expect_valid = s_r_hs && occ == 0;
            occ = occ + int'(s_r_hs) - int'(s_m_hs);
            prev_m_stall = m_valid && !m_ready;
            prev_m_data  = m_data;
            prev_m_last  = m_last;
            prev_ar_wait = arvalid && !arready;
            prev_araddr  = araddr;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            pending = 1'b0; k_beat = 0; gbeat = 0; ar_wait = cfg_stall;
            rvalid = 1'b0; arready = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        end else begin
            if (s_ar_hs) begin
                pending = 1'b1; raddr = s_araddr; k_beat = 0; ar_wait = cfg_stall;
            end else if (s_arvalid && ar_wait > 0) begin
                ar_wait--;
            end
            if (s_r_hs) begin
                k_beat++; gbeat++;
                if (k_beat == BL) pending = 1'b0;
            end
            arready = (ar_wait == 0);
            if (!pending) rvalid = 1'b0;
            else if (!s_rvalid || s_r_hs) rvalid = cfg_rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            rdata = 128'((raddr - TB_BASE) >> 4) + 128'(k_beat);
            rlast = ((k_beat == BL - 1) != (gbeat == cfg_last_beat));
            rresp = (gbeat == cfg_resp_beat) ? 2'b10 : 2'b00;
        end
        case (cfg_mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = mr_pat[cyc % 4];
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_frame(input bit sel);
        frame_sel = sel;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, busy, 0);
    endtask

    task automatic run_frame(input string tag, input bit sel);
        build_expected(sel);
        start_frame(sel);
        check({tag, "_busy_set"}, busy, 1);
        wait_idle(tag);
        tick();
        tick();
        check({tag, "_words_left"}, exp_w.size(), 0);
        check({tag, "_bursts_left"}, exp_ar.size(), 0);
        check({tag, "_m_valid_idle"}, m_valid, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_m_data"}, m_data, 0);
    endtask

    typedef struct {
        bit          sel;
        int          stall;
        bit          rv_rand;
        int          mr_mode;
        int          resp_beat;
        int          last_beat;
        bit          exp_err;
        logic [31:0] exp_ar0;
    } case_t;

    initial begin
        case_t cases[8];
        int n;
        cases[0] = '{1'b0, 0,  1'b0, 0, -1, -1, 1'b0, 32'h1000_0000};
        cases[1] = '{1'b1, 0,  1'b0, 0, -1, -1, 1'b0, 32'h1000_0100};
        cases[2] = '{1'b0, 0,  1'b1, 1, -1, -1, 1'b0, 32'h1000_0000};
        cases[3] = '{1'b1, 10, 1'b0, 0, -1, -1, 1'b0, 32'h1000_0100};
        cases[4] = '{1'b0, 0,  1'b0, 0,  2, -1, 1'b1, 32'h1000_0000};
        cases[5] = '{1'b0, 0,  1'b0, 0, -1,  1, 1'b1, 32'h1000_0000};
        cases[6] = '{1'b1, 0,  1'b1, 2, -1, -1, 1'b0, 32'h1000_0100};
        cases[7] = '{1'b0, 3,  1'b1, 2, -1, -1, 1'b0, 32'h1000_0000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");
        check("arlen_static", arlen, 3);
        check("arsize_static", arsize, 4);
        check("arburst_static", arburst, 1);
        check("arcache_static", arcache, 3);
        check("arlock_static", arlock, 0);
        check("arprot_static", arprot, 0);
        check("arqos_static", arqos, 0);
        check("arid_static", arid, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_stall = cases[i].stall;
            cfg_rv_rand = cases[i].rv_rand;
            cfg_mr_mode = cases[i].mr_mode;
            cfg_resp_beat = cases[i].resp_beat;
            cfg_last_beat = cases[i].last_beat;
            do_reset();
            run_frame($sformatf("case%0d", i), cases[i].sel);
            check($sformatf("case%0d_first_ar", i), first_ar, cases[i].exp_ar0);
            check($sformatf("case%0d_err", i), err, cases[i].exp_err);
            check($sformatf("case%0d_overrun", i), overrun, 0);
        end

        // Start while busy sets overrun; reset during burst 1 abandons it.
        cfg_stall = 0; cfg_rv_rand = 1'b0; cfg_mr_mode = 0;
        cfg_resp_beat = -1; cfg_last_beat = -1;
        do_reset();
        build_expected(1'b0);
        start_frame(1'b0);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        check("ovr_first_word_seen", m_valid, 1);
        start_frame(1'b1);
        check("overrun_set", overrun, 1);
        check("overrun_busy", busy, 1);
        n = 0;
        while (gbeat < BL + 1 && n < 200) begin
            tick();
            n++;
        end
        check("mid_burst1_reached", gbeat >= BL + 1, 1);
        do_reset();
        check_idle("after_reset");
        repeat (3) tick();
        check("after_reset_quiet_arvalid", arvalid, 0);
        check("after_reset_quiet_busy", busy, 0);
        cfg_mr_mode = 2;
        run_frame("post_reset", 1'b1);
        check("post_reset_err", err, 0);
        check("post_reset_overrun", overrun, 0);

        // Start in the same cycle as the final m_last handshake.
        cfg_mr_mode = 0;
        do_reset();
        build_expected(1'b0);
        start_frame(1'b0);
        n = 0;
        while (!(m_valid && m_last) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sim_last_seen", m_valid && m_last, 1);
        frame_sel = 1'b0;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("sim_overrun", overrun, 1);
        check("sim_busy_low", busy, 0);
        repeat (4) tick();
        check("sim_no_restart_arvalid", arvalid, 0);
        check("sim_no_restart_busy", busy, 0);
        check("sim_words_left", exp_w.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
